// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
// Holds the FSM state enum, the counter-width helper and the Booth bit-pair codes.
package booth_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    // Encodings of the {Qr[0], q_m1} pair that change the accumulator
    localparam logic [1:0] PAIR_ADD = 2'b01;
    localparam logic [1:0] PAIR_SUB = 2'b10;

    // Counter must hold WIDTH+1 when the unsigned mode is built in
    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/subtract/no-op on the accumulator followed
// by an arithmetic right shift of {A, Qr, q_m1}.
module booth_step
    import booth_pkg::*;
#(
    parameter int AW = 9,
    parameter int QW = 8
) (
    input  logic signed [AW-1:0] a_i,
    input  logic        [QW-1:0] qr_i,
    input  logic                 qm1_i,
    input  logic signed [AW-1:0] m_i,
    output logic signed [AW-1:0] a_o,
    output logic        [QW-1:0] qr_o,
    output logic                 qm1_o
);

    logic signed [AW-1:0] sum;

    always_comb begin
        sum = a_i;
        case ({qr_i[0], qm1_i})
            PAIR_ADD: sum = a_i + m_i;
            PAIR_SUB: sum = a_i - m_i;
            default:  sum = a_i;
        endcase
        // Shift: A's sign bit is replicated, A's LSB falls into Qr
        a_o   = {sum[AW-1], sum[AW-1:1]};
        qr_o  = {sum[0], qr_i[QW-1:1]};
        qm1_o = qr_i[0];
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with busy/done handshake and held product.
// Optional BOOTH_UNSIGNED_EN adds the is_signed port and an unsigned mode.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      start,
    input  logic signed [WIDTH-1:0]   M,
    input  logic signed [WIDTH-1:0]   Q,
`ifdef BOOTH_UNSIGNED_EN
    input  logic                      is_signed,
`endif
    output logic        [2*WIDTH-1:0] product,
    output logic                      busy,
    output logic                      done
);

`ifdef BOOTH_UNSIGNED_EN
    // Unsigned operands need one extra multiplier bit and one extra accumulator bit
    localparam int AW = WIDTH + 2;
    localparam int QW = WIDTH + 1;
`else
    localparam int AW = WIDTH + 1;
    localparam int QW = WIDTH;
`endif
    localparam int CNT_W = cnt_width(WIDTH);

    state_t                  state_q;
    logic signed [AW-1:0]    a_q, m_q, a_d, m_ld;
    logic        [QW-1:0]    qr_q, qr_d, qr_ld;
    logic                    qm1_q, qm1_d;
    logic        [CNT_W-1:0] cnt_q, n_ld;
    logic        [2*WIDTH-1:0] product_q, prod_d;
    logic                    busy_q, done_q;

    booth_step #(.AW(AW), .QW(QW)) u_step (
        .a_i  (a_q),
        .qr_i (qr_q),
        .qm1_i(qm1_q),
        .m_i  (m_q),
        .a_o  (a_d),
        .qr_o (qr_d),
        .qm1_o(qm1_d)
    );

`ifdef BOOTH_UNSIGNED_EN
    logic signed_q;

    always_comb begin
        m_ld  = {{(AW-WIDTH){is_signed & M[WIDTH-1]}}, M};
        qr_ld = {is_signed & Q[WIDTH-1], Q};
        n_ld  = is_signed ? CNT_W'(WIDTH) : CNT_W'(WIDTH + 1);
        // Signed runs stop one shift early, leaving the unused Q sign bit in Qr[0]
        prod_d = signed_q ? {a_d[WIDTH-1:0], qr_d[WIDTH:1]}
                          : {a_d[WIDTH-2:0], qr_d};
    end
`else
    always_comb begin
        m_ld   = {M[WIDTH-1], M};
        qr_ld  = Q;
        n_ld   = CNT_W'(WIDTH);
        prod_d = {a_d[WIDTH-1:0], qr_d};
    end
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            m_q       <= '0;
            qr_q      <= '0;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef BOOTH_UNSIGNED_EN
            signed_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q      <= '0;
                        m_q      <= m_ld;
                        qr_q     <= qr_ld;
                        qm1_q    <= 1'b0;
                        cnt_q    <= n_ld;
                        busy_q   <= 1'b1;
                        state_q  <= CALC;
`ifdef BOOTH_UNSIGNED_EN
                        signed_q <= is_signed;
`endif
                    end
                end
                CALC: begin
                    a_q   <= a_d;
                    qr_q  <= qr_d;
                    qm1_q <= qm1_d;
                    cnt_q <= cnt_q - 1'b1;
                    // Last iteration: publish the post-shift result
                    if (cnt_q == CNT_W'(1)) begin
                        product_q <= prod_d;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
            endcase
        end
    end

    assign product = product_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
